// File: rtl/oled_frame_sequencer.sv
// SSD1306 128x32 frame sequencer: plays the init ROM once after reset, then on each
// start sends the window setup and the 512-byte framebuffer, one I2C transaction per byte.
//
// state     | meaning
// INIT_LOAD | latch init ROM byte, command control byte
// WIN_LOAD  | latch window ROM byte, command control byte
// FB_REQ    | fb_rd high, RAM fetching fb_addr
// FB_LOAD   | latch RAM data, data control byte
// ISSUE     | wait for controller idle, then pulse i2c_enable
// WAIT_BUSY | wait for controller to go busy, re-issue on timeout
// WAIT_DONE | wait for controller to finish the byte
// NEXT      | advance index / address / phase
// IDLE      | busy low, waiting for start
module oled_frame_sequencer #(
  parameter logic [6:0] DEV_ADDR     = 7'h3C,
  parameter int         N_INIT       = 25,
  parameter int         FB_BYTES     = 512,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fb_rd,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_ctrl,
  output logic [7:0] i2c_data,
  output logic       i2c_enable,
  input  logic       i2c_ready
);

  typedef enum logic [3:0] {
    INIT_LOAD, WIN_LOAD, FB_REQ, FB_LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT, IDLE
  } state_t;

  typedef enum logic [1:0] {PH_INIT, PH_WIN, PH_FB} phase_t;

  localparam int               TMR_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(BUSY_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(1);
  localparam logic [4:0]       INIT_LAST = 5'(N_INIT - 1);
  localparam logic [4:0]       WIN_LAST  = 5'd5;
  localparam logic [8:0]       FB_LAST   = 9'(FB_BYTES - 1);
  localparam logic [7:0]       CTRL_CMD  = 8'h00;
  localparam logic [7:0]       CTRL_DATA = 8'h40;

  state_t           state;
  phase_t           phase;
  logic [4:0]       idx;
  logic [TMR_W-1:0] tmr;
  logic             pending;

  function automatic logic [7:0] init_rom(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:  b = 8'hAE;
      5'd1:  b = 8'hD5;
      5'd2:  b = 8'h80;
      5'd3:  b = 8'hA8;
      5'd4:  b = 8'h1F;
      5'd5:  b = 8'hD3;
      5'd6:  b = 8'h00;
      5'd7:  b = 8'h40;
      5'd8:  b = 8'h8D;
      5'd9:  b = 8'h14;
      5'd10: b = 8'h20;
      5'd11: b = 8'h00;
      5'd12: b = 8'hA1;
      5'd13: b = 8'hC8;
      5'd14: b = 8'hDA;
      5'd15: b = 8'h02;
      5'd16: b = 8'h81;
      5'd17: b = 8'h8F;
      5'd18: b = 8'hD9;
      5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;
      5'd21: b = 8'h40;
      5'd22: b = 8'hA4;
      5'd23: b = 8'hA6;
      5'd24: b = 8'hAF;
      default: b = 8'hE3;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] win_rom(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0: b = 8'h21;
      5'd1: b = 8'h00;
      5'd2: b = 8'h7F;
      5'd3: b = 8'h22;
      5'd4: b = 8'h00;
      5'd5: b = 8'h03;
      default: b = 8'hE3;
    endcase
    return b;
  endfunction

  assign i2c_addr = DEV_ADDR;
  assign i2c_rw   = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT_LOAD;
      phase      <= PH_INIT;
      idx        <= 5'd0;
      tmr        <= '0;
      pending    <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      fb_rd      <= 1'b0;
      fb_addr    <= 9'd0;
      i2c_ctrl   <= 8'h00;
      i2c_data   <= 8'h00;
      i2c_enable <= 1'b0;
    end else begin
      i2c_enable <= 1'b0;
      done       <= 1'b0;
      fb_rd      <= 1'b0;
      if (start && state != IDLE) pending <= 1'b1;

      case (state)
        INIT_LOAD: begin
          i2c_data <= init_rom(idx);
          i2c_ctrl <= CTRL_CMD;
          state    <= ISSUE;
        end
        WIN_LOAD: begin
          i2c_data <= win_rom(idx);
          i2c_ctrl <= CTRL_CMD;
          state    <= ISSUE;
        end
        FB_REQ: state <= FB_LOAD;
        FB_LOAD: begin
          i2c_data <= fb_data;
          i2c_ctrl <= CTRL_DATA;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (i2c_ready) begin
            i2c_enable <= 1'b1;
            tmr        <= TMR_LOAD;
            state      <= WAIT_BUSY;
          end
        end
        // Timeout is counted from the enable cycle itself.
        WAIT_BUSY: begin
          if (!i2c_ready)            state <= WAIT_DONE;
          else if (tmr == TMR_LAST)  state <= ISSUE;
          else                       tmr   <= tmr - TMR_LAST;
        end
        WAIT_DONE: begin
          if (i2c_ready) state <= NEXT;
        end
        NEXT: begin
          case (phase)
            PH_INIT: begin
              if (idx == INIT_LAST) begin
                idx <= 5'd0;
                if (pending || start) begin
                  pending <= 1'b0;
                  phase   <= PH_WIN;
                  state   <= WIN_LOAD;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end else begin
                idx   <= idx + 5'd1;
                state <= INIT_LOAD;
              end
            end
            PH_WIN: begin
              if (idx == WIN_LAST) begin
                idx   <= 5'd0;
                phase <= PH_FB;
                fb_rd <= 1'b1;
                state <= FB_REQ;
              end else begin
                idx   <= idx + 5'd1;
                state <= WIN_LOAD;
              end
            end
            default: begin
              if (fb_addr == FB_LAST) begin
                fb_addr <= 9'd0;
                done    <= 1'b1;
                // A queued start chains straight into the next refresh.
                if (pending || start) begin
                  pending <= 1'b0;
                  phase   <= PH_WIN;
                  state   <= WIN_LOAD;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end else begin
                fb_addr <= fb_addr + 9'd1;
                fb_rd   <= 1'b1;
                state   <= FB_REQ;
              end
            end
          endcase
        end
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            phase <= PH_WIN;
            idx   <= 5'd0;
            state <= WIN_LOAD;
          end
        end
        default: state <= INIT_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Bench for oled_frame_sequencer: I2C controller model logs each completed byte,
// checked in order against a scoreboard of expected {ctrl, data} pairs.
module tb_oled_frame_sequencer;

  localparam int BUSY_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, fb_rd;
  logic [8:0] fb_addr;
  logic [7:0] fb_data = 8'h00;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [7:0] i2c_ctrl, i2c_data;
  logic       i2c_enable;
  logic       i2c_ready = 1'b1;

  oled_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
    .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_ctrl(i2c_ctrl),
    .i2c_data(i2c_data), .i2c_enable(i2c_enable), .i2c_ready(i2c_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer RAM holding addr[7:0], one cycle read latency.
  always @(posedge clk) if (fb_rd) fb_data <= fb_addr[7:0];

  // I2C controller model.
  int          lat_cfg = 20;
  int          ignore_idx = -1;
  int          long_idx = -1;
  int          en_cnt = 0;
  int          hold_cnt = 0;
  int          log_wr = 0;
  logic [15:0] cap = 16'h0;
  logic [15:0] log_mem [0:4095];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      i2c_ready <= 1'b1;
      hold_cnt  <= 0;
    end else if (!i2c_ready) begin
      if (hold_cnt <= 1) begin
        i2c_ready       <= 1'b1;
        log_mem[log_wr] <= cap;
        log_wr          <= log_wr + 1;
      end else begin
        hold_cnt <= hold_cnt - 1;
      end
    end else if (i2c_enable) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt != ignore_idx) begin
        i2c_ready <= 1'b0;
        cap       <= {i2c_ctrl, i2c_data};
        hold_cnt  <= (en_cnt == long_idx) ? 1000 : lat_cfg;
      end
    end
  end

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] data;
  } vec_t;

  localparam logic [7:0] INIT_BYTES [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  localparam logic [7:0] WIN_BYTES [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  vec_t        init_vec [25];
  vec_t        win_vec [6];
  logic [15:0] sb [$];
  int          rd_ptr = 0;
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          done_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drain();
    logic [15:0] e;
    while (rd_ptr < log_wr) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_extra: got %0h, want no byte", log_mem[rd_ptr]);
      end else begin
        e = sb.pop_front();
        check("bus_byte", {16'h0, log_mem[rd_ptr]}, {16'h0, e});
      end
      rd_ptr++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drain();
  endtask

  task automatic push_init();
    for (int i = 0; i < 25; i++) sb.push_back({init_vec[i].ctrl, init_vec[i].data});
  endtask

  task automatic push_refresh();
    logic [15:0] v;
    for (int i = 0; i < 6; i++) sb.push_back({win_vec[i].ctrl, win_vec[i].data});
    for (int i = 0; i < 512; i++) begin
      v = i[15:0];
      sb.push_back({8'h40, v[7:0]});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    done_cnt = 0;
    done_bad = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
      if (done === 1'b1) begin
        done_cnt++;
        if (fb_addr !== 9'd0) done_bad++;
      end
    end
    check({name, "_idle_within_budget"}, (n < budget), 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int          n, k, en0, first_idx;
    int          t [2];
    logic [15:0] d [2];
    logic [15:0] held;
    int          en_during, chg_during;
    bit          s3;

    for (int i = 0; i < 25; i++) init_vec[i] = '{ctrl: 8'h00, data: INIT_BYTES[i]};
    for (int i = 0; i < 6; i++)  win_vec[i]  = '{ctrl: 8'h00, data: WIN_BYTES[i]};

    // Reset values
    tick(); tick(); tick();
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_fb_rd", fb_rd, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_ctrl", i2c_ctrl, 8'h00);
    check("rst_data", i2c_data, 8'h00);
    check("rst_enable", i2c_enable, 0);
    check("i2c_addr", i2c_addr, 7'h3C);
    check("i2c_rw", i2c_rw, 0);

    // 1: init ROM with 20-cycle transactions
    lat_cfg = 20;
    push_init();
    en0 = en_cnt;
    rst = 1'b1;
    wait_idle("init", 3000);
    check("init_enables", en_cnt - en0, 25);
    check("init_sb_empty", sb.size(), 0);
    check("init_busy_low", busy, 0);
    check("init_no_done", done_cnt, 0);

    // 2: one refresh
    push_refresh();
    en0 = en_cnt;
    pulse_start();
    check("ref_busy_high", busy, 1);
    wait_idle("refresh", 20000);
    check("ref_enables", en_cnt - en0, 518);
    check("ref_done_once", done_cnt, 1);
    check("ref_done_addr0", done_bad, 0);
    check("ref_fb_addr0", fb_addr, 0);
    check("ref_sb_empty", sb.size(), 0);

    // 4: first enable ignored, byte re-issued after the busy timeout
    lat_cfg = 3;
    ignore_idx = en_cnt;
    push_refresh();
    pulse_start();
    n = 0; k = 0; done_cnt = 0;
    while (busy === 1'b1 && n < 10000) begin
      tick();
      n++;
      if (done === 1'b1) done_cnt++;
      if (i2c_enable === 1'b1 && k < 2) begin
        t[k] = cyc;
        d[k] = {i2c_ctrl, i2c_data};
        k++;
      end
    end
    check("reissue_within_budget", (n < 10000), 1);
    check("reissue_enables_seen", k, 2);
    check("reissue_gap", t[1] - t[0], BUSY_TIMEOUT + 1);
    check("reissue_first_byte", d[0], 16'h0021);
    check("reissue_same_byte", d[1], 16'h0021);
    check("reissue_done_once", done_cnt, 1);
    check("reissue_sb_empty", sb.size(), 0);

    // 6: controller holds ready low for 1000 cycles on the third window byte
    long_idx = en_cnt + 2;
    push_refresh();
    pulse_start();
    n = 0;
    while (!(i2c_ready === 1'b0 && en_cnt == long_idx + 1) && n < 200) begin
      tick();
      n++;
    end
    check("hold_reached", (n < 200), 1);
    held = {i2c_ctrl, i2c_data};
    check("hold_byte", held, 16'h007F);
    en_during = 0;
    chg_during = 0;
    for (int i = 0; i < 980; i++) begin
      tick();
      if (i2c_enable !== 1'b0) en_during++;
      if ({i2c_ctrl, i2c_data} !== held) chg_during++;
    end
    check("hold_no_enable", en_during, 0);
    check("hold_stable", chg_during, 0);
    check("hold_still_busy", busy, 1);
    wait_idle("hold_resume", 10000);
    check("hold_done_once", done_cnt, 1);
    check("hold_sb_empty", sb.size(), 0);

    // 5: reset during framebuffer byte 100
    push_refresh();
    pulse_start();
    n = 0;
    while (!(i2c_enable === 1'b1 && fb_addr == 9'd100) && n < 5000) begin
      tick();
      n++;
    end
    check("mid_reset_reached", (n < 5000), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_enable", i2c_enable, 0);
    check("mid_reset_busy", busy, 1);
    check("mid_reset_fb_addr", fb_addr, 0);
    check("mid_reset_ctrl", i2c_ctrl, 8'h00);
    tick(); tick();
    sb.delete();
    push_init();
    first_idx = log_wr;
    rst = 1'b1;
    wait_idle("reinit", 3000);
    check("reinit_first_byte", log_mem[first_idx], 16'h00AE);
    check("reinit_sb_empty", sb.size(), 0);

    // 3: starts during init and during refresh -> two chained refreshes
    rst = 1'b0;
    tick(); tick(); tick();
    sb.delete();
    lat_cfg = 3;
    push_init();
    push_refresh();
    push_refresh();
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    pulse_start();
    tick(); tick();
    pulse_start();
    n = 0; done_cnt = 0; s3 = 1'b0;
    while (busy === 1'b1 && n < 20000) begin
      if (!s3 && done_cnt == 0 && fb_addr == 9'd50) begin
        start = 1'b1;
        s3 = 1'b1;
      end
      tick();
      n++;
      start = 1'b0;
      if (done === 1'b1) done_cnt++;
    end
    check("chain_within_budget", (n < 20000), 1);
    check("chain_done_twice", done_cnt, 2);
    check("chain_sb_empty", sb.size(), 0);
    en0 = en_cnt;
    for (int i = 0; i < 100; i++) tick();
    check("chain_no_third", en_cnt - en0, 0);
    check("chain_busy_low", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
